// File: rtl/enigma_pkg.sv
// Shared types, constants and helpers for the enigma core arbiter.
// The symbol encoding is signed 7-bit. Letters are 1..26 and 0 marks an idle slot.
package enigma_pkg;

    typedef logic signed [6:0] symb_t;

    localparam symb_t LETTER_MIN = 7'sd1;
    localparam symb_t LETTER_MAX = 7'sd26;
    localparam symb_t SYMB_IDLE  = 7'sd0;

    typedef enum logic [1:0] {
        StIdle,
        StCoreRst,
        StAccept,
        StWait
    } arb_state_e;

    function automatic logic is_letter(input symb_t s);
        return (s >= LETTER_MIN) && (s <= LETTER_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker. The search starts one past the last owner.
// Only the last-owner pointer is registered; everything else is combinational.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_adv,
    input  logic [ID_W-1:0] i_owner,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_id
);

    logic [ID_W-1:0] r_last_owner;
    logic            w_found;
    int unsigned     w_idx;

    always_comb begin
        o_gnt   = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = (32'(r_last_owner) + i) % NREQ;
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_id         = ID_W'(w_idx);
            end
        end
    end

    // Reset value makes requester 0 the first candidate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_owner <= ID_W'(NREQ - 1);
        end else if (i_adv) begin
            r_last_owner <= i_owner;
        end
    end

endmodule

// File: rtl/enigma_arbiter.sv
// Per-message arbiter sharing one stateful enigma core between NREQ sources.
// It resets the core before each message and forwards one symbol at a time.
module enigma_arbiter
    import enigma_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned CORE_LAT = 2,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned ID_W    = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       msg_req_i,
    input  logic [NREQ*CNT_W-1:0] msg_len_i,
    output logic [NREQ-1:0]       msg_gnt_o,
    input  logic [NREQ-1:0]       sym_valid_i,
    input  logic [NREQ*7-1:0]     sym_i,
    output logic [NREQ-1:0]       sym_ready_o,
    output logic                  res_valid_o,
    output logic [6:0]            res_symb_o,
    output logic [ID_W-1:0]       res_id_o,
    output logic                  res_last_o,
    output logic                  busy_o,
    output logic                  core_rst_no,
    output logic [6:0]            core_symb_o,
    input  logic [6:0]            core_symb_i
);

    localparam int unsigned LAT_W = 4;

    arb_state_e      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [ID_W-1:0] r_id;
    logic [CNT_W-1:0] r_rem;
    logic [LAT_W-1:0] r_cnt;
    logic            r_res_valid;
    logic            r_res_last;
    symb_t           r_res_symb;
    logic [ID_W-1:0] r_res_id;
    logic            r_core_rst_n;
    symb_t           r_core_symb;

    logic [NREQ-1:0] w_arb_gnt;
    logic [ID_W-1:0] w_arb_id;
    logic [CNT_W-1:0] w_len;
    symb_t           w_sym;
    logic            w_adv;
    logic            w_hs;
    logic            w_last;
    logic            w_emit;
    symb_t           w_emit_symb;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_req   (msg_req_i),
        .i_adv   (w_adv),
        .i_owner (w_arb_id),
        .o_gnt   (w_arb_gnt),
        .o_id    (w_arb_id)
    );

    assign w_adv  = (r_state == StIdle) && (|msg_req_i);
    assign w_len  = msg_len_i[w_arb_id*CNT_W +: CNT_W];
    assign w_sym  = sym_i[r_id*7 +: 7];
    assign w_hs   = (r_state == StAccept) && sym_valid_i[r_id];
    assign w_last = (r_rem == CNT_W'(1));

    // A result comes either straight from a non-letter handshake or from the core.
    always_comb begin
        w_emit      = 1'b0;
        w_emit_symb = SYMB_IDLE;
        if (w_hs && !is_letter(w_sym)) begin
            w_emit      = 1'b1;
            w_emit_symb = w_sym;
        end else if ((r_state == StWait) && (r_cnt == '0)) begin
            w_emit      = 1'b1;
            w_emit_symb = core_symb_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= StIdle;
            r_gnt        <= '0;
            r_id         <= '0;
            r_rem        <= '0;
            r_cnt        <= '0;
            r_res_valid  <= 1'b0;
            r_res_last   <= 1'b0;
            r_res_symb   <= SYMB_IDLE;
            r_res_id     <= '0;
            r_core_rst_n <= 1'b0;
            r_core_symb  <= SYMB_IDLE;
        end else begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_core_symb <= SYMB_IDLE;
            if (w_emit) begin
                r_res_valid <= 1'b1;
                r_res_symb  <= w_emit_symb;
                r_res_id    <= r_id;
                r_res_last  <= w_last;
                r_rem       <= r_rem - CNT_W'(1);
            end
            case (r_state)
                StIdle: begin
                    // Grant of the finished message is held one cycle into IDLE.
                    r_core_rst_n <= 1'b1;
                    r_gnt        <= '0;
                    if (w_adv) begin
                        r_gnt <= w_arb_gnt;
                        r_id  <= w_arb_id;
                        r_rem <= w_len;
                        if (w_len != '0) begin
                            r_state      <= StCoreRst;
                            r_core_rst_n <= 1'b0;
                        end
                    end
                end
                StCoreRst: begin
                    r_core_rst_n <= 1'b1;
                    r_state      <= StAccept;
                end
                StAccept: begin
                    if (w_hs) begin
                        if (w_emit) begin
                            r_state <= w_last ? StIdle : StAccept;
                        end else begin
                            r_core_symb <= w_sym;
                            r_cnt       <= LAT_W'(CORE_LAT);
                            r_state     <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (w_emit) begin
                        r_state <= w_last ? StIdle : StAccept;
                    end else begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign msg_gnt_o   = r_gnt;
    assign sym_ready_o = (r_state == StAccept) ? r_gnt : '0;
    assign busy_o      = (r_state != StIdle);
    assign res_valid_o = r_res_valid;
    assign res_symb_o  = r_res_symb;
    assign res_id_o    = r_res_id;
    assign res_last_o  = r_res_last;
    assign core_rst_no = r_core_rst_n;
    assign core_symb_o = r_core_symb;

endmodule

// File: tb/tb_enigma_arbiter.sv
// Directed bench for enigma_arbiter with a stub core returning sym+1 after CORE_LAT.
module tb_enigma_arbiter;
    import enigma_pkg::*;

    localparam int NREQ     = 4;
    localparam int CORE_LAT = 2;
    localparam int CNT_W    = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b0;
    logic [NREQ-1:0]       msg_req_i = '0;
    logic [NREQ*CNT_W-1:0] msg_len_i = '0;
    logic [NREQ-1:0]       msg_gnt_o;
    logic [NREQ-1:0]       sym_valid_i = '0;
    logic [NREQ*7-1:0]     sym_i = '0;
    logic [NREQ-1:0]       sym_ready_o;
    logic                  res_valid_o;
    logic [6:0]            res_symb_o;
    logic [1:0]            res_id_o;
    logic                  res_last_o;
    logic                  busy_o;
    logic                  core_rst_no;
    logic [6:0]            core_symb_o;
    logic [6:0]            core_symb_i;

    int total = 0;
    int bad   = 0;

    enigma_arbiter #(
        .NREQ     (NREQ),
        .CORE_LAT (CORE_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .msg_req_i   (msg_req_i),
        .msg_len_i   (msg_len_i),
        .msg_gnt_o   (msg_gnt_o),
        .sym_valid_i (sym_valid_i),
        .sym_i       (sym_i),
        .sym_ready_o (sym_ready_o),
        .res_valid_o (res_valid_o),
        .res_symb_o  (res_symb_o),
        .res_id_o    (res_id_o),
        .res_last_o  (res_last_o),
        .busy_o      (busy_o),
        .core_rst_no (core_rst_no),
        .core_symb_o (core_symb_o),
        .core_symb_i (core_symb_i)
    );

    always #5 clk_i = ~clk_i;

    // Stub core: two-stage delay, output = input + 1.
    symb_t d1 = '0;
    symb_t d2 = '0;
    always @(posedge clk_i) begin
        d1 <= core_symb_o;
        d2 <= d1;
    end
    assign core_symb_i = d2 + 7'sd1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_gnt;
        int n = 0;
        do begin
            tick();
            n++;
        end while (msg_gnt_o == '0 && n < 20);
    endtask

    // Present one symbol to requester r and capture its result (lat=-1 on timeout).
    task automatic drive_sym(input int r, input symb_t s, output int lat, output symb_t rs,
                             output logic [1:0] rid, output logic rlast, output int pulses,
                             output symb_t pval);
        int n = 0;
        lat = -1; rs = '0; rid = '0; rlast = 1'b0; pulses = 0; pval = '0;
        while (!sym_ready_o[r] && n < 20) begin
            tick();
            n++;
        end
        if (!sym_ready_o[r]) return;
        sym_valid_i[r] = 1'b1;
        sym_i[r*7 +: 7] = s;
        tick();
        sym_valid_i[r] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (core_symb_o != 7'd0) begin
                if (pulses == 0) pval = core_symb_o;
                pulses++;
            end
            if (res_valid_o) begin
                lat = k; rs = res_symb_o; rid = res_id_o; rlast = res_last_o;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        tick();
        tick();
        total++;
        if ({msg_gnt_o, sym_ready_o, res_valid_o, res_symb_o, res_id_o, res_last_o, busy_o,
             core_rst_no, core_symb_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got gnt=%b rv=%b busy=%b crst=%b exp all zero",
                     msg_gnt_o, res_valid_o, busy_o, core_rst_no);
        end
        rst_i = 1'b1;
        tick();
        total++;
        if (core_rst_no !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got crst=%b busy=%b exp crst=1 busy=0",
                     core_rst_no, busy_o);
        end
    endtask

    task automatic test_round_robin;
        int lat, pl; symb_t rs, pv; logic [1:0] rid; logic rl;
        for (int r = 0; r < NREQ; r++) msg_len_i[r*CNT_W +: CNT_W] = 8'd1;
        msg_req_i = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            wait_gnt();
            total++;
            if (msg_gnt_o !== 4'(1 << i)) begin
                bad++;
                $display("FAIL rr_order%0d got=%b exp=%b", i, msg_gnt_o, 4'(1 << i));
            end
            msg_req_i[i] = 1'b0;
            drive_sym(i, 7'sd1, lat, rs, rid, rl, pl, pv);
            total++;
            if (rs !== 7'sd2 || rid !== 2'(i) || rl !== 1'b1) begin
                bad++;
                $display("FAIL rr_result%0d got sym=%0d id=%0d last=%b exp sym=2 id=%0d last=1",
                         i, rs, rid, rl, i);
            end
        end
        msg_req_i = 4'b0101;
        wait_gnt();
        total++;
        if (msg_gnt_o !== 4'b0001) begin
            bad++;
            $display("FAIL rr_wrap got=%b exp=0001", msg_gnt_o);
        end
        msg_req_i[0] = 1'b0;
        drive_sym(0, 7'sd1, lat, rs, rid, rl, pl, pv);
        wait_gnt();
        total++;
        if (msg_gnt_o !== 4'b0100) begin
            bad++;
            $display("FAIL rr_next got=%b exp=0100", msg_gnt_o);
        end
        msg_req_i[2] = 1'b0;
        drive_sym(2, 7'sd1, lat, rs, rid, rl, pl, pv);
    endtask

    task automatic test_single;
        symb_t syms[3] = '{7'sd8, 7'sd5, 7'sd12};
        symb_t exps[3] = '{7'sd9, 7'sd6, 7'sd13};
        int lat, pl; symb_t rs, pv; logic [1:0] rid; logic rl;
        msg_len_i[7:0] = 8'd3;
        msg_req_i[0] = 1'b1;
        wait_gnt();
        total++;
        if (msg_gnt_o !== 4'b0001 || core_rst_no !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got gnt=%b crst=%b busy=%b exp gnt=0001 crst=0 busy=1",
                     msg_gnt_o, core_rst_no, busy_o);
        end
        msg_req_i[0] = 1'b0;
        tick();
        total++;
        if (core_rst_no !== 1'b1 || sym_ready_o !== 4'b0001) begin
            bad++;
            $display("FAIL single_accept got crst=%b ready=%b exp crst=1 ready=0001",
                     core_rst_no, sym_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive_sym(0, syms[i], lat, rs, rid, rl, pl, pv);
            total++;
            if (rs !== exps[i] || rid !== 2'd0 || lat !== 4 || rl !== (i == 2)) begin
                bad++;
                $display("FAIL single_res%0d got sym=%0d id=%0d lat=%0d last=%b exp sym=%0d id=0 lat=4 last=%b",
                         i, rs, rid, lat, rl, exps[i], (i == 2));
            end
            total++;
            if (pl !== 1 || pv !== syms[i]) begin
                bad++;
                $display("FAIL single_core%0d got pulses=%0d val=%0d exp pulses=1 val=%0d",
                         i, pl, pv, syms[i]);
            end
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL single_idle got busy=%b exp=0", busy_o);
        end
        tick();
        total++;
        if (msg_gnt_o !== 4'b0000) begin
            bad++;
            $display("FAIL single_gnt_clear got=%b exp=0000", msg_gnt_o);
        end
    endtask

    task automatic test_nonletter;
        symb_t syms[3] = '{7'sd8, 7'sd0, 7'sd30};
        symb_t exps[3] = '{7'sd9, 7'sd0, 7'sd30};
        int    elat[3] = '{4, 1, 1};
        int    epl[3]  = '{1, 0, 0};
        int lat, pl; symb_t rs, pv; logic [1:0] rid; logic rl;
        msg_len_i[7:0] = 8'd3;
        msg_req_i[0] = 1'b1;
        wait_gnt();
        msg_req_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_sym(0, syms[i], lat, rs, rid, rl, pl, pv);
            total++;
            if (rs !== exps[i] || lat !== elat[i] || pl !== epl[i] || rl !== (i == 2)) begin
                bad++;
                $display("FAIL nonletter%0d got sym=%0d lat=%0d pulses=%0d last=%b exp sym=%0d lat=%0d pulses=%0d last=%b",
                         i, rs, lat, pl, rl, exps[i], elat[i], epl[i], (i == 2));
            end
        end
    endtask

    task automatic test_lock;
        symb_t syms[4] = '{7'sd3, 7'sd4, 7'sd5, 7'sd6};
        int lat, pl; symb_t rs, pv; logic [1:0] rid; logic rl;
        msg_len_i[15:8] = 8'd4;
        msg_req_i[1] = 1'b1;
        wait_gnt();
        total++;
        if (msg_gnt_o !== 4'b0010) begin
            bad++;
            $display("FAIL lock_grant got=%b exp=0010", msg_gnt_o);
        end
        for (int i = 0; i < 4; i++) begin
            drive_sym(1, syms[i], lat, rs, rid, rl, pl, pv);
            msg_req_i[1] = 1'b0;
            total++;
            if (rs !== syms[i] + 7'sd1 || rid !== 2'd1 || rl !== (i == 3)) begin
                bad++;
                $display("FAIL lock_res%0d got sym=%0d id=%0d last=%b exp sym=%0d id=1 last=%b",
                         i, rs, rid, rl, syms[i] + 7'sd1, (i == 3));
            end
        end
    endtask

    task automatic test_len0;
        logic quiet = 1'b1;
        msg_len_i[31:24] = 8'd0;
        msg_req_i[3] = 1'b1;
        wait_gnt();
        total++;
        if (msg_gnt_o !== 4'b1000 || core_rst_no !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL len0_grant got gnt=%b crst=%b busy=%b exp gnt=1000 crst=1 busy=0",
                     msg_gnt_o, core_rst_no, busy_o);
        end
        msg_req_i[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (msg_gnt_o !== 4'b0000 || res_valid_o || !core_rst_no || busy_o) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL len0_quiet got activity=1 exp activity=0");
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        logic stale = 1'b0;
        int lat, pl; symb_t rs, pv; logic [1:0] rid; logic rl;
        msg_len_i[23:16] = 8'd2;
        msg_req_i[2] = 1'b1;
        wait_gnt();
        msg_req_i[2] = 1'b0;
        while (!sym_ready_o[2] && n < 20) begin
            tick();
            n++;
        end
        sym_valid_i[2] = 1'b1;
        sym_i[20:14] = 7'sd10;
        tick();
        sym_valid_i[2] = 1'b0;
        total++;
        if (core_symb_o !== 7'sd10 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_inflight got core=%0d busy=%b exp core=10 busy=1",
                     core_symb_o, busy_o);
        end
        tick();
        rst_i = 1'b0;
        #1;
        total++;
        if ({msg_gnt_o, sym_ready_o, res_valid_o, res_symb_o, res_id_o, res_last_o, busy_o,
             core_rst_no, core_symb_o} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs got gnt=%b rv=%b busy=%b crst=%b core=%0d exp all zero",
                     msg_gnt_o, res_valid_o, busy_o, core_rst_no, core_symb_o);
        end
        tick();
        tick();
        msg_len_i[7:0] = 8'd1;
        msg_req_i = 4'b0101;
        rst_i = 1'b1;
        n = 0;
        do begin
            tick();
            if (res_valid_o) stale = 1'b1;
            n++;
        end while (msg_gnt_o == '0 && n < 20);
        total++;
        if (msg_gnt_o !== 4'b0001 || stale !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_regrant got gnt=%b stale=%b exp gnt=0001 stale=0",
                     msg_gnt_o, stale);
        end
        msg_req_i = 4'b0000;
        drive_sym(0, 7'sd2, lat, rs, rid, rl, pl, pv);
        total++;
        if (rs !== 7'sd3 || rl !== 1'b1 || rid !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_after got sym=%0d last=%b id=%0d exp sym=3 last=1 id=0",
                     rs, rl, rid);
        end
    endtask

    task automatic test_backpressure;
        logic held = 1'b1;
        int lat, pl; symb_t rs, pv; logic [1:0] rid; logic rl;
        msg_len_i[7:0] = 8'd1;
        msg_req_i[0] = 1'b1;
        tick();
        wait_gnt();
        msg_req_i[0] = 1'b0;
        tick();
        sym_valid_i[2] = 1'b1;
        sym_i[20:14] = 7'sd5;
        for (int c = 0; c < 5; c++) begin
            if (sym_ready_o !== 4'b0001 || core_symb_o !== 7'd0 || res_valid_o) held = 1'b0;
            tick();
        end
        sym_valid_i[2] = 1'b0;
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold got stalled_ok=0 exp stalled_ok=1");
        end
        drive_sym(0, 7'sd26, lat, rs, rid, rl, pl, pv);
        total++;
        if (rs !== 7'sd27 || lat !== 4 || rl !== 1'b1) begin
            bad++;
            $display("FAIL bp_result got sym=%0d lat=%0d last=%b exp sym=27 lat=4 last=1",
                     rs, lat, rl);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_nonletter();
        test_lock();
        test_len0();
        test_reset_mid();
        test_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
